xrv_mem_arb: RTL and testbench
==============================

Name: xrv_mem_arb

Overview:
- Single-port instruction/data memory arbiter for the xrv core.
- Shares one synchronous SRAM port between two requesters: the instruction fetcher (read-only stream) and the load/store unit (read/write).
- Load/store has priority; a starvation counter guarantees fetch progress.
- Routes 1-cycle-latency read data back to the owner; drops fetch responses invalidated by a jump flush.

Parameters:
STARVE_MAX, 4, consecutive LS grants allowed while if_req pending before IF is forced a grant (1..15)
MEM_AW, 32, byte address width presented to memory

Ports:
clk  in  1  clock
rstb  in  1  asynchronous active-low reset
if_req  in  1  fetch read request
if_addr  in  32  fetch byte address
if_flush  in  1  jump flush pulse from fetch/branch logic
if_gnt  out  1  fetch request accepted this cycle
if_rdata  out  32  fetch read data
if_rvalid  out  1  fetch read data valid
ls_req  in  1  load/store request
ls_we  in  1  1 = store, 0 = load
ls_be  in  4  store byte enables
ls_addr  in  32  load/store byte address
ls_wdata  in  32  store data
ls_gnt  out  1  load/store request accepted this cycle
ls_rdata  out  32  load data
ls_rvalid  out  1  load data valid / store acknowledge
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_be  out  4  memory byte enables
mem_addr  out  MEM_AW  word-aligned byte address ([1:0] forced 0)
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid 1 cycle after mem_en

Behaviour:
Reset:
- Reset applies to rstb asynchronous active-low, clk.
- While rstb is low: if_gnt, ls_gnt, if_rvalid, ls_rvalid and mem_en are 0; if_rdata and ls_rdata are 0; FSM is in IDLE; starve_cnt is 0.
- Reset mid-transaction discards any in-flight response.

Grant (combinational, same cycle as request):
- ls_gnt = ls_req & ~force_if.
- if_gnt = if_req & ~if_flush & (~ls_req | force_if).
- force_if = (starve_cnt == STARVE_MAX).
- At most one grant per cycle.
- mem_* are driven from the winner; mem_en = if_gnt | ls_gnt.
- An IF grant drives mem_we = 0 and mem_be = 4'hF.
- When there is no grant, mem_we, mem_be and mem_wdata are 0.

Starvation counter (4-bit):
- Increments on a cycle with ls_gnt & if_req.
- Clears on if_gnt, or on any cycle with if_req = 0.
- Saturates at STARVE_MAX.

Response FSM (registered, records the owner of the previous cycle's access):
- IDLE: no access last cycle.
- RESP_IF: IF read in flight.
- RESP_LS: LS access in flight.
- RESP_DROP: IF read in flight but flushed.
- Next state from this cycle's grant: ls_gnt -> RESP_LS; if_gnt -> RESP_IF; no grant -> IDLE.
- if_flush while in RESP_IF: the current cycle's response is suppressed; no state change is needed because the suppression is combinational.
- if_flush in the cycle an IF read is granted is impossible (the grant is blocked).
- if_flush in the cycle after the grant makes the response drop.
- RESP_DROP is entered when an IF grant coincides with a flush registered the same edge. Use it if flush is pipelined; otherwise it is unreachable.

Outputs:
- if_rvalid = (state == RESP_IF) & ~if_flush.
- ls_rvalid = (state == RESP_LS); this covers both loads and stores.
- if_rdata and ls_rdata carry mem_rdata when their rvalid is 1, else 0.

Latency and throughput:
- Read data arrives exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle; full throughput, no bubbles.

Simultaneous events:
- ls_req & if_req: LS wins unless force_if.
- ls_req & if_flush: LS is granted, unaffected by the flush.

Decomposition:
- xrv_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, RESP_IF, RESP_LS, RESP_DROP};
  - localparam XRV_STARVE_W = 4.
- Single module; no sub-module. The grant logic, counter and FSM stay flat.

Test Plan:
- if_req = 1 continuous, if_addr = 0x100, 0x104 … -> if_gnt every cycle; mem_addr follows; if_rvalid = 1 one cycle later with if_rdata = mem_rdata.
- ls_req = 1, ls_we = 0, ls_addr = 0x2002, same cycle as if_req -> ls_gnt = 1, if_gnt = 0; mem_addr = 0x2000; next cycle ls_rvalid = 1, if_rvalid = 0.
- ls_req held high 6 cycles with if_req high, STARVE_MAX = 4 -> LS granted cycles 0-3, IF granted cycle 4 (ls_gnt = 0), LS resumes cycle 5; starve_cnt returns to 0.
- IF granted at cycle N, if_flush = 1 at cycle N+1 -> if_rvalid stays 0 at N+1; if_req at N+1 not granted.
- Store ls_we = 1, ls_be = 4'b0011, ls_wdata = 0xDEADBEEF -> mem_we = 1, mem_be = 0011, mem_wdata = 0xDEADBEEF same cycle; ls_rvalid ack next cycle.
- rstb asserted low the cycle after an LS grant -> ls_rvalid = 0, mem_en = 0 immediately; after release the FSM is IDLE and the first if_req is granted.

Source files
------------

// File: rtl/xrv_pkg.sv
// Shared types and constants for the xrv core memory subsystem.
//   arb_state_t  : response tracking state of the memory arbiter
//   XRV_STARVE_W : width of the arbiter fetch-starvation counter
package xrv_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP_IF   = 2'd1,
        RESP_LS   = 2'd2,
        RESP_DROP = 2'd3
    } arb_state_t;

    localparam int XRV_STARVE_W = 4;

endpackage

// File: rtl/xrv_mem_arb.sv
// Single-port memory arbiter for the xrv core.
// Shares one synchronous SRAM port (1-cycle read latency) between the
// instruction fetcher (read-only) and the load/store unit (read/write).
// Load/store has priority; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive load/store grants while a fetch is waiting.
// Read data is routed back to whichever requester owned the previous
// cycle's access; a fetch response is suppressed by a jump flush.
//
// Ports:
//   clk, rstb                     clock, asynchronous active-low reset
//   if_req/if_addr/if_flush       fetch request, byte address, jump flush
//   if_gnt/if_rdata/if_rvalid     fetch grant, read data, data valid
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata   load/store request
//   ls_gnt/ls_rdata/ls_rvalid     load/store grant, load data, valid/ack
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata  memory request port
//   mem_rdata                     memory read data, 1 cycle after mem_en
module xrv_mem_arb
    import xrv_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int MEM_AW     = 32
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic [31:0]       if_rdata,
    output logic              if_rvalid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic [31:0]       ls_rdata,
    output logic              ls_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [XRV_STARVE_W-1:0] STARVE_LIM = XRV_STARVE_W'(STARVE_MAX);

    logic [XRV_STARVE_W-1:0] starve_cnt;
    arb_state_t              state;
    logic                    force_if;
    logic [31:0]             sel_addr;

    assign force_if = (starve_cnt == STARVE_LIM);

    // Grants are combinational; gating with rstb keeps the port quiet while
    // reset is held, independent of requester activity.
    assign ls_gnt = rstb & ls_req & ~force_if;
    assign if_gnt = rstb & if_req & ~if_flush & (~ls_req | force_if);
    assign mem_en = if_gnt | ls_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        sel_addr  = '0;
        if (ls_gnt) begin
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_wdata = ls_wdata;
            sel_addr  = ls_addr;
        end else if (if_gnt) begin
            mem_be    = '1;
            sel_addr  = if_addr;
        end
    end

    // Word-aligned address: low two byte-offset bits forced to zero.
    assign mem_addr = MEM_AW'(sel_addr & 32'hFFFF_FFFC);

    // Response state records the owner of this cycle's access so the
    // read data arriving next cycle is routed to it. RESP_DROP exists for
    // a pipelined-flush variant; with a combinational flush it is never
    // entered and simply produces no response.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            if (ls_gnt)
                state <= RESP_LS;
            else if (if_gnt)
                state <= RESP_IF;
            else
                state <= IDLE;

            if (!if_req || if_gnt)
                starve_cnt <= '0;
            else if (ls_gnt && !force_if)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // A flush arriving while a fetch read is in flight kills that response.
    assign if_rvalid = (state == RESP_IF) & ~if_flush;
    assign ls_rvalid = (state == RESP_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_xrv_mem_arb.sv
// Self-checking bench for xrv_mem_arb: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_xrv_mem_arb;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rstb;
    logic        if_req, if_flush;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    xrv_mem_arb #(.STARVE_MAX(SMAX), .MEM_AW(32)) dut (
        .clk(clk), .rstb(rstb),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rdata(ls_rdata),
        .ls_rvalid(ls_rvalid), .mem_en(mem_en), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model state: who owns the access whose data returns this cycle
    // (0 none, 1 fetch, 2 load/store) and how many LS wins a waiting
    // fetch has sat through.
    int m_owner  = 0;
    int m_starve = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic drive(input bit ir, input logic [31:0] ia, input bit fl,
                         input bit lr, input bit we, input logic [3:0] be,
                         input logic [31:0] la, input logic [31:0] wd);
        if_req = ir; if_addr = ia; if_flush = fl;
        ls_req = lr; ls_we = we; ls_be = be; ls_addr = la; ls_wdata = wd;
        mem_rdata = $urandom;
    endtask

    // Called just after a falling edge with inputs applied: checks every
    // output against the model, then advances the model over the rising edge.
    task automatic step();
        bit e_ls, e_if, e_ifv, e_lsv, forced;
        #1;
        forced = (m_starve == SMAX);
        e_ls   = rstb && ls_req && !forced;
        e_if   = rstb && if_req && !if_flush && (!ls_req || forced);
        e_ifv  = rstb && (m_owner == 1) && !if_flush;
        e_lsv  = rstb && (m_owner == 2);
        check("ls_gnt", 32'(ls_gnt), 32'(e_ls));
        check("if_gnt", 32'(if_gnt), 32'(e_if));
        check("mem_en", 32'(mem_en), 32'(e_ls || e_if));
        check("mem_we", 32'(mem_we), e_ls ? 32'(ls_we) : 32'd0);
        check("mem_be", 32'(mem_be), e_ls ? 32'(ls_be) : (e_if ? 32'hF : 32'h0));
        check("mem_wdata", mem_wdata, e_ls ? ls_wdata : 32'h0);
        if (e_ls) check("mem_addr_ls", mem_addr, {ls_addr[31:2], 2'b00});
        if (e_if) check("mem_addr_if", mem_addr, {if_addr[31:2], 2'b00});
        check("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
        check("ls_rvalid", 32'(ls_rvalid), 32'(e_lsv));
        check("if_rdata", if_rdata, e_ifv ? mem_rdata : 32'h0);
        check("ls_rdata", ls_rdata, e_lsv ? mem_rdata : 32'h0);
        @(posedge clk);
        if (!rstb) begin
            m_owner  = 0;
            m_starve = 0;
        end else begin
            m_owner = e_ls ? 2 : (e_if ? 1 : 0);
            if (!if_req || e_if) m_starve = 0;
            else if (e_ls && m_starve < SMAX) m_starve++;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstb = 1'b0;
        drive(1, 32'h100, 0, 1, 1, 4'hF, 32'h40, 32'h1234);
        @(negedge clk);
        // Reset with both requests asserted: everything must be quiet.
        step();
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        rstb = 1'b1;

        // Continuous fetch stream.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h100 + 32'(4 * i), 0, 0, 0, 4'h0, 32'h0, 32'h0);
            step();
        end

        // Load collides with fetch at an unaligned address.
        drive(1, 32'h110, 0, 1, 0, 4'hF, 32'h2002, 32'h0);
        #1 check("tp_ld_addr", mem_addr, 32'h2000);
        check("tp_ld_ifgnt", 32'(if_gnt), 32'd0);
        step();
        drive(0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1 check("tp_ld_rvalid", 32'(ls_rvalid), 32'd1);
        step();

        // Starvation: LS held 6 cycles with fetch waiting.
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h200, 0, 1, 0, 4'hF, 32'h3000 + 32'(4 * i), 32'h0);
            #1 check("tp_starve_ls", 32'(ls_gnt), (i == 4) ? 32'd0 : 32'd1);
            step();
        end

        // Fetch granted, flushed the following cycle.
        drive(1, 32'h300, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        step();
        drive(1, 32'h304, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        #1 check("tp_flush_rv", 32'(if_rvalid), 32'd0);
        check("tp_flush_gnt", 32'(if_gnt), 32'd0);
        step();

        // Partial store.
        drive(0, 32'h0, 0, 1, 1, 4'b0011, 32'h4000, 32'hDEADBEEF);
        #1 check("tp_st_wdata", mem_wdata, 32'hDEADBEEF);
        check("tp_st_be", 32'(mem_be), 32'h3);
        step();

        // Reset the cycle after an LS grant.
        drive(1, 32'h500, 0, 1, 0, 4'hF, 32'h5000, 32'h0);
        step();
        rstb = 1'b0;
        #1 check("tp_rst_lsrv", 32'(ls_rvalid), 32'd0);
        check("tp_rst_memen", 32'(mem_en), 32'd0);
        step();
        rstb = 1'b1;
        drive(1, 32'h600, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1 check("tp_post_rst_gnt", 32'(if_gnt), 32'd1);
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  4'($urandom), $urandom, $urandom);
            rstb = ($urandom_range(0, 99) != 0);
            step();
        end
        rstb = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
